// File: rtl/memory_stage.sv
// memory_stage: dual-slot MEM stage; slot 0's access strictly precedes slot 1's on one dmem port.
// Optional MEM_TIMEOUT_EN: an access unacked for TIMEOUT_CYCLES is aborted and bus_err latches.
package memory_stage_pkg;
  typedef struct packed {
    logic        valid;
    logic        mem_read;
    logic        mem_write;
    logic        mem_size;
    logic [31:0] mem_addr;
    logic [15:0] store_data;
    logic [15:0] alu_result;
    logic [15:0] alu_result2;
    logic [3:0]  rd_addr;
    logic        rd_we;
    logic [3:0]  rd2_addr;
    logic        rd2_we;
    logic        z_flag;
    logic        v_flag;
    logic        is_halt;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] wb_data;
    logic [15:0] wb_data2;
    logic [3:0]  rd_addr;
    logic        rd_we;
    logic [3:0]  rd2_addr;
    logic        rd2_we;
    logic        z_flag;
    logic        v_flag;
    logic        is_halt;
  } mem_wb_t;
endpackage

module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  ex_mem_t           ex_mem_0,
  input  ex_mem_t           ex_mem_1,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic              dmem_size,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [15:0]       dmem_rdata,
  output mem_wb_t           mem_wb_0,
  output mem_wb_t           mem_wb_1,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1} state_t;

  state_t      state_q, state_d;
  ex_mem_t     hold0_q, hold0_d;
  ex_mem_t     hold1_q, hold1_d;
  logic [15:0] ld0_q, ld0_d;
  logic        halt0_q, halt0_d;
  mem_wb_t     wb0_q, wb0_d;
  mem_wb_t     wb1_q, wb1_d;
  logic        bus_err_q, bus_err_d;

  logic        sel1;
  logic        acc_size;
  logic        timeout_hit;
  logic        acc_done;
  logic        acc_to;
  logic [15:0] acc_data;

  function automatic logic is_mem(input ex_mem_t s);
    return s.valid && (s.mem_read || s.mem_write);
  endfunction

  function automatic logic [15:0] load_fmt(input logic size, input logic [15:0] d);
    return size ? d : {8'h00, d[7:0]};
  endfunction

  // ld is only used when the slot is a valid pure load; halt folds in an aborted access
  function automatic mem_wb_t to_wb(input ex_mem_t s, input logic [15:0] ld, input logic halt);
    mem_wb_t w;
    w.valid    = s.valid;
    w.wb_data  = (s.valid && s.mem_read && !s.mem_write) ? ld : s.alu_result;
    w.wb_data2 = s.alu_result2;
    w.rd_addr  = s.rd_addr;
    w.rd_we    = s.rd_we;
    w.rd2_addr = s.rd2_addr;
    w.rd2_we   = s.rd2_we;
    w.z_flag   = s.z_flag;
    w.v_flag   = s.v_flag;
    w.is_halt  = s.is_halt | halt;
    return w;
  endfunction

  assign sel1       = (state_q == ACC1);
  assign stall      = (state_q != IDLE);
  assign dmem_req   = (state_q != IDLE);
  assign dmem_we    = sel1 ? hold1_q.mem_write : hold0_q.mem_write;
  assign acc_size   = sel1 ? hold1_q.mem_size  : hold0_q.mem_size;
  assign dmem_size  = acc_size;
  assign dmem_addr  = sel1 ? hold1_q.mem_addr[ADDR_W-1:0] : hold0_q.mem_addr[ADDR_W-1:0];
  assign dmem_wdata = sel1 ? load_fmt(hold1_q.mem_size, hold1_q.store_data)
                           : load_fmt(hold0_q.mem_size, hold0_q.store_data);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_q, wait_d;

  assign timeout_hit = (state_q != IDLE) && (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle and on every completion, so each ACCx starts counting from zero
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE || acc_done) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign timeout_hit    = 1'b0;
`endif

  // A real ack wins over a timeout landing in the same cycle
  assign acc_done = dmem_ack | timeout_hit;
  assign acc_to   = timeout_hit & ~dmem_ack;
  assign acc_data = dmem_ack ? load_fmt(acc_size, dmem_rdata) : 16'h0000;

  always_comb begin
    state_d   = state_q;
    hold0_d   = hold0_q;
    hold1_d   = hold1_q;
    ld0_d     = ld0_q;
    halt0_d   = halt0_q;
    wb0_d     = wb0_q;
    wb1_d     = wb1_q;
    bus_err_d = bus_err_q | acc_to;
    case (state_q)
      IDLE: begin
        if (is_mem(ex_mem_0) || is_mem(ex_mem_1)) begin
          hold0_d = ex_mem_0;
          hold1_d = ex_mem_1;
          halt0_d = 1'b0;
          wb0_d   = '0;
          wb1_d   = '0;
          state_d = is_mem(ex_mem_0) ? ACC0 : ACC1;
        end else begin
          wb0_d = to_wb(ex_mem_0, 16'h0000, 1'b0);
          wb1_d = to_wb(ex_mem_1, 16'h0000, 1'b0);
        end
      end
      ACC0: begin
        if (acc_done) begin
          ld0_d   = acc_data;
          halt0_d = acc_to;
          if (is_mem(hold1_q)) begin
            state_d = ACC1;
          end else begin
            wb0_d   = to_wb(hold0_q, acc_data, acc_to);
            wb1_d   = to_wb(hold1_q, 16'h0000, 1'b0);
            state_d = IDLE;
          end
        end
      end
      ACC1: begin
        if (acc_done) begin
          wb0_d   = to_wb(hold0_q, ld0_q, halt0_q);
          wb1_d   = to_wb(hold1_q, acc_data, acc_to);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold0_q   <= '0;
      hold1_q   <= '0;
      ld0_q     <= '0;
      halt0_q   <= 1'b0;
      wb0_q     <= '0;
      wb1_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold0_q   <= hold0_d;
      hold1_q   <= hold1_d;
      ld0_q     <= ld0_d;
      halt0_q   <= halt0_d;
      wb0_q     <= wb0_d;
      wb1_q     <= wb1_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign mem_wb_0 = wb0_q;
  assign mem_wb_1 = wb1_q;
  assign bus_err  = bus_err_q;

endmodule
